click_seq: RTL
==============

CLICK_SEQ -- requirements
Module: click_seq

Interface
REQ-001 Parameter DB_N, default 250000, debounce window in clk cycles (minimum 2).
REQ-002 Parameter LONG_N, default 125000000, press duration in clk cycles that classifies as a long press (LONG_N > DB_N).
REQ-003 Parameter GAP_N, default 37500000, maximum release-to-second-press window in clk cycles for a double click (GAP_N > DB_N).
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous assertion, active-low.
REQ-006 button  input  1  raw, bouncing, asynchronous push-button level; 1 = pressed.
REQ-007 single  output  1  one-cycle pulse on a classified single click.
REQ-008 double  output  1  one-cycle pulse on a classified double click.
REQ-009 long  output  1  one-cycle pulse on a classified long press.
REQ-010 led  output  1  indicator level; toggles on each single pulse; forced to 0 on long pulse.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 The block SHALL pass button through a two-flop synchronizer before any other use.
REQ-013 The debounced level db SHALL change only after the synchronized level has differed from db on DB_N consecutive rising edges; any cycle of agreement SHALL clear the debounce counter.
REQ-014 Timer and debounce counters SHALL be wide enough for the largest parameter and SHALL saturate, never wrap.
REQ-015 FSM states SHALL be IDLE, DOWN1, UP_WAIT, DOWN2 and LONG_HELD.
REQ-016 IDLE: db rising -> DOWN1, timer cleared.
REQ-017 DOWN1: db falling -> UP_WAIT, timer cleared; timer reaching LONG_N-1 with db high -> LONG_HELD and long pulse.
REQ-018 UP_WAIT: db rising -> DOWN2, timer cleared; timer reaching GAP_N-1 with db low -> IDLE, single pulse, led toggled.
REQ-019 DOWN2: db falling -> IDLE and double pulse; timer reaching LONG_N-1 with db high -> LONG_HELD and long pulse, with no double pulse.
REQ-020 LONG_HELD: db falling -> IDLE; no pulse is generated while in LONG_HELD regardless of hold time.
REQ-021 If a db edge and timer expiry occur on the same edge, the db edge SHALL take priority.
REQ-022 Pulses SHALL be registered, asserted for exactly one cycle on the edge following the qualifying transition condition, and mutually exclusive.
REQ-023 A third press arriving in IDLE after a double pulse SHALL start a new sequence in DOWN1.

Reset
REQ-024 While rst is low: FSM = IDLE, db = 0, synchronizer flops = 0, all counters = 0, and single = double = long = led = busy = 0.
REQ-025 Reset asserted mid-sequence SHALL abort the sequence with no pulse; a button held through reset release SHALL be debounced from db = 0 and count as a new press.

Verification (bench parameters DB_N=4, LONG_N=40, GAP_N=20)
REQ-026 Raw 1-cycle glitches on button every 3 cycles for 30 cycles -> db stays 0, busy stays 0, no pulses.
REQ-027 Press held 10 cycles, then release -> exactly one single pulse, GAP_N cycles after db falls; led 0->1; busy returns to 0.
REQ-028 Two 10-cycle presses separated by a 10-cycle gap -> one double pulse on the second db fall; no single pulse; led unchanged.
REQ-029 Press held 100 cycles -> one long pulse 40 cycles after db rises; led = 0; no further pulse on release.
REQ-030 Press followed by rst low for 2 cycles while still in DOWN1 -> all outputs 0 immediately; no pulse follows; a held button re-registers after 2+DB_N cycles.
REQ-031 Bouncy press (on/off toggling every cycle for 6 cycles, then stable high for 10 cycles, then bouncy release) -> exactly one single pulse.

Source files
------------

// File: rtl/click_seq.sv
// Push-button click classifier: synchronizes and debounces a raw button, then
// sorts presses into single, double and long clicks with one-cycle pulses.
module click_seq #(
  parameter int DB_N   = 250000,
  parameter int LONG_N = 125000000,
  parameter int GAP_N  = 37500000
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic single,
  output logic double,
  output logic long,
  output logic led,
  output logic busy
);

  localparam int TMAX = (LONG_N > GAP_N) ? LONG_N : GAP_N;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int DW   = $clog2(DB_N + 1);

  localparam logic [TW-1:0] T_LONG  = TW'(LONG_N - 1);
  localparam logic [TW-1:0] T_GAP   = TW'(GAP_N - 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DB_N - 1);

  typedef enum logic [2:0] {IDLE, DOWN1, UP_WAIT, DOWN2, LONG_HELD} state_t;

  state_t          state;
  logic            s1, s2, db;
  logic [DW-1:0]   dbcnt;
  logic [TW-1:0]   timer;
  logic            flip, rise, fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= button;
      s2 <= s1;
    end
  end

  // flip fires on the DB_N-th consecutive disagreeing edge; the FSM sees the
  // edge strobe on the same clock that db itself changes
  assign flip = (s2 != db) && (dbcnt == DB_LAST);
  assign rise = flip & s2;
  assign fall = flip & ~s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db    <= 1'b0;
      dbcnt <= '0;
    end else if (s2 == db) begin
      dbcnt <= '0;
    end else if (flip) begin
      db    <= s2;
      dbcnt <= '0;
    end else if (dbcnt != '1) begin
      dbcnt <= dbcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      timer  <= '0;
      single <= 1'b0;
      double <= 1'b0;
      long   <= 1'b0;
      led    <= 1'b0;
    end else begin
      single <= 1'b0;
      double <= 1'b0;
      long   <= 1'b0;
      if (timer != '1) timer <= timer + 1'b1;
      // db edges are tested first so they win over a coincident timer expiry
      case (state)
        IDLE: if (rise) begin
          state <= DOWN1;
          timer <= '0;
        end
        DOWN1: if (fall) begin
          state <= UP_WAIT;
          timer <= '0;
        end else if (db && timer == T_LONG) begin
          state <= LONG_HELD;
          long  <= 1'b1;
          led   <= 1'b0;
        end
        UP_WAIT: if (rise) begin
          state <= DOWN2;
          timer <= '0;
        end else if (!db && timer == T_GAP) begin
          state  <= IDLE;
          single <= 1'b1;
          led    <= ~led;
        end
        DOWN2: if (fall) begin
          state  <= IDLE;
          double <= 1'b1;
        end else if (db && timer == T_LONG) begin
          state <= LONG_HELD;
          long  <= 1'b1;
          led   <= 1'b0;
        end
        LONG_HELD: if (fall) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
